// File: rtl/actor_stream_pkg.sv
// actor_stream_pkg: shared types, constants and helpers for the actor stream blocks
package actor_stream_pkg;
  localparam logic [15:0] TOKEN_COUNT = 16'h1;
  typedef enum logic {IDLE, BURST} state_t;
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr, input int n);
    int idx;
    rr_pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && req[idx[1:0]]) rr_pick = idx[1:0];
    end
  endfunction
  function automatic int clog2(input int v);
    clog2 = 0;
    while ((1 << clog2) < v) clog2++;
  endfunction
endpackage

// File: rtl/actor_stream_fifo2.sv
// actor_stream_fifo2: two-entry registered token buffer with head output
module actor_stream_fifo2 #(
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [1:0]    fcount,
  output logic [DW-1:0] head
);
  logic [DW-1:0] tail;
  // head holds the oldest token; a pop shifts tail forward, a push fills the first free slot
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      fcount <= '0;
      head   <= '0;
      tail   <= '0;
    end else begin
      if (push && (fcount == 2'd0 || (pop && fcount == 2'd1))) head <= din;
      else if (pop && fcount == 2'd2) head <= tail;
      if (push && ((fcount == 2'd1 && !pop) || (fcount == 2'd2 && pop))) tail <= din;
      fcount <= fcount + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/actor_stream_rr_merge.sv
// actor_stream_rr_merge: round-robin burst merge of N_IN token streams into one consumer
module actor_stream_rr_merge
  import actor_stream_pkg::*;
#(
  parameter int N_IN      = 2,
  parameter int DW        = 16,
  parameter int BURST_LEN = 512,
  parameter int BCW       = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [N_IN*DW-1:0] In_DATA,
  input  logic [N_IN*16-1:0] In_COUNT,
  input  logic [N_IN-1:0]    In_SEND,
  output logic [N_IN-1:0]    In_ACK,
  output logic [DW-1:0]      Out_DATA,
  output logic [15:0]        Out_COUNT,
  output logic               Out_SEND,
  input  logic               Out_ACK,
  input  logic               Out_RDY,
  output logic [1:0]         Grant_ID,
  output logic               Busy
);
  state_t state;
  logic [1:0] rr_ptr, pick, fcount;
  logic [BCW-1:0] bcnt;
  logic [DW-1:0] push_data;
  logic push, pop, last, unused_count;
  assign unused_count = ^In_COUNT;
  assign Out_COUNT = TOKEN_COUNT;
  assign Busy = state == BURST;
  assign pick = rr_pick(4'(In_SEND), rr_ptr, N_IN);
  assign push = |In_ACK;
  assign pop = Out_SEND & Out_ACK;
  assign Out_SEND = (fcount != 2'd0) & Out_RDY;
  assign last = bcnt == BCW'(BURST_LEN - 1);
  // Only the granted port is acknowledged, and only while the buffer has a free slot
  always_comb begin
    In_ACK = '0;
    push_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      In_ACK[i] = Busy && Grant_ID == 2'(i) && In_SEND[i] && fcount != 2'd2;
      if (Grant_ID == 2'(i)) push_data = In_DATA[i*DW +: DW];
    end
  end
  // Arbitrate in IDLE, then hold the grant until BURST_LEN tokens have been taken
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      Grant_ID <= '0;
      bcnt     <= '0;
    end else if (state == IDLE) begin
      if (|In_SEND) begin
        state    <= BURST;
        Grant_ID <= pick;
        rr_ptr   <= pick == 2'(N_IN - 1) ? 2'd0 : pick + 2'd1;
        bcnt     <= '0;
      end
    end else if (push) begin
      state <= last ? IDLE : BURST;
      bcnt  <= last ? '0 : bcnt + BCW'(1);
    end
  actor_stream_fifo2 #(.DW(DW)) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .fcount(fcount),
    .head  (Out_DATA)
  );
endmodule

// File: tb/tb_actor_stream_rr_merge.sv
// tb_actor_stream_rr_merge: reference-model and table-driven bench for the round-robin merge
module tb_actor_stream_rr_merge;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  logic [31:0] a_data = '0;
  logic [31:0] a_cnt = 32'h0001_0001;
  logic [1:0]  a_send = '0, a_ack, a_gid;
  logic [15:0] a_odata, a_ocnt;
  logic        a_osend, a_oack = 1'b0, a_rdy = 1'b0, a_busy;

  logic [47:0] b_data = {16'h0C02, 16'h0B01, 16'h0A00};
  logic [47:0] b_cnt = {16'h1, 16'h1, 16'h1};
  logic [2:0]  b_send = '0, b_ack;
  logic [1:0]  b_gid;
  logic [15:0] b_odata, b_ocnt;
  logic        b_osend, b_oack = 1'b0, b_rdy = 1'b0, b_busy;

  actor_stream_rr_merge #(.N_IN(2), .DW(16), .BURST_LEN(4), .BCW(16)) u_a (
    .CLK(CLK), .RESET(RESET), .In_DATA(a_data), .In_COUNT(a_cnt), .In_SEND(a_send),
    .In_ACK(a_ack), .Out_DATA(a_odata), .Out_COUNT(a_ocnt), .Out_SEND(a_osend),
    .Out_ACK(a_oack), .Out_RDY(a_rdy), .Grant_ID(a_gid), .Busy(a_busy)
  );
  actor_stream_rr_merge #(.N_IN(3), .DW(16), .BURST_LEN(1), .BCW(16)) u_b (
    .CLK(CLK), .RESET(RESET), .In_DATA(b_data), .In_COUNT(b_cnt), .In_SEND(b_send),
    .In_ACK(b_ack), .Out_DATA(b_odata), .Out_COUNT(b_ocnt), .Out_SEND(b_osend),
    .Out_ACK(b_oack), .Out_RDY(b_rdy), .Grant_ID(b_gid), .Busy(b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for instance A: grant owner, tokens left in burst, buffer as a queue
  bit          m_busy;
  int          m_gid, m_ptr, m_left;
  logic [15:0] m_q[$];
  logic [15:0] p_next[2];
  int          acc_log[$];
  logic [15:0] out_log[$];

  task automatic do_reset();
    RESET = 1'b1;
    a_send = '0; a_rdy = 1'b0; a_oack = 1'b0;
    b_send = '0; b_rdy = 1'b0; b_oack = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    m_busy = 0; m_gid = 0; m_ptr = 0; m_left = 0;
    m_q.delete(); acc_log.delete(); out_log.delete();
    p_next[0] = 16'h100; p_next[1] = 16'h200;
  endtask

  task automatic cyc_a(input logic [1:0] send, input logic rdy, input logic oack);
    logic [1:0] eack;
    logic eos;
    int g;
    a_send = send; a_rdy = rdy; a_oack = oack;
    a_data = {p_next[1], p_next[0]};
    eack = '0;
    for (int i = 0; i < 2; i++) eack[i] = m_busy && m_gid == i && send[i] && m_q.size() < 2;
    eos = m_q.size() != 0 && rdy;
    @(negedge CLK);
    chk("a_in_ack", 32'(a_ack), 32'(eack));
    chk("a_out_send", 32'(a_osend), 32'(eos));
    if (eos) chk("a_out_data", 32'(a_odata), 32'(m_q[0]));
    chk("a_busy", 32'(a_busy), 32'(m_busy));
    chk("a_grant", 32'(a_gid), 32'(m_gid));
    chk("a_out_count", 32'(a_ocnt), 32'h1);
    if (eos && oack) out_log.push_back(m_q.pop_front());
    if (m_busy) begin
      if (eack != 0) begin
        m_q.push_back(p_next[m_gid]);
        acc_log.push_back(m_gid);
        p_next[m_gid]++;
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end else if (send != 0) begin
      g = m_ptr;
      while (!send[g]) g = (g + 1) % 2;
      m_gid = g; m_ptr = (g + 1) % 2; m_busy = 1; m_left = 4;
    end
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [2:0]  send;
    logic        rdy, oack;
    logic [2:0]  ack;
    logic        os;
    logic [15:0] od;
    logic [1:0]  gid;
    logic        busy;
  } vec_t;
  vec_t tv[12];

  initial begin
    int n0;
    logic [15:0] ev;
    tv[0]  = '{3'b111, 1'b1, 1'b1, 3'b000, 1'b0, 16'h0000, 2'd0, 1'b0};
    tv[1]  = '{3'b111, 1'b1, 1'b1, 3'b001, 1'b0, 16'h0000, 2'd0, 1'b1};
    tv[2]  = '{3'b111, 1'b1, 1'b1, 3'b000, 1'b1, 16'h0A00, 2'd0, 1'b0};
    tv[3]  = '{3'b111, 1'b1, 1'b1, 3'b010, 1'b0, 16'h0000, 2'd1, 1'b1};
    tv[4]  = '{3'b111, 1'b1, 1'b1, 3'b000, 1'b1, 16'h0B01, 2'd1, 1'b0};
    tv[5]  = '{3'b111, 1'b1, 1'b1, 3'b100, 1'b0, 16'h0000, 2'd2, 1'b1};
    tv[6]  = '{3'b111, 1'b1, 1'b1, 3'b000, 1'b1, 16'h0C02, 2'd2, 1'b0};
    tv[7]  = '{3'b111, 1'b1, 1'b1, 3'b001, 1'b0, 16'h0000, 2'd0, 1'b1};
    tv[8]  = '{3'b001, 1'b0, 1'b1, 3'b000, 1'b0, 16'h0000, 2'd0, 1'b0};
    tv[9]  = '{3'b001, 1'b0, 1'b1, 3'b001, 1'b0, 16'h0000, 2'd0, 1'b1};
    tv[10] = '{3'b010, 1'b0, 1'b1, 3'b000, 1'b0, 16'h0000, 2'd0, 1'b0};
    tv[11] = '{3'b010, 1'b1, 1'b0, 3'b000, 1'b1, 16'h0A00, 2'd1, 1'b1};

    do_reset();
    repeat (10) cyc_a(2'b00, 1'b1, 1'b1);

    do_reset();
    repeat (20) cyc_a(2'b11, 1'b1, 1'b1);
    chk("stream_len", 32'(out_log.size() >= 12), 32'h1);
    for (int k = 0; k < 12 && k < out_log.size(); k++) begin
      ev = k < 4 ? 16'(16'h100 + k) : k < 8 ? 16'(16'h200 + k - 4) : 16'(16'h104 + k - 8);
      chk("stream_order", 32'(out_log[k]), 32'(ev));
      if (k < acc_log.size()) chk("stream_grant", 32'(acc_log[k]), 32'((k / 4) % 2));
    end

    do_reset();
    repeat (3) cyc_a(2'b11, 1'b1, 1'b1);
    repeat (5) cyc_a(2'b10, 1'b1, 1'b1);
    repeat (4) cyc_a(2'b11, 1'b1, 1'b1);
    chk("lock_len", 32'(acc_log.size()), 32'd5);
    for (int k = 0; k < 5 && k < acc_log.size(); k++) chk("lock_grant", 32'(acc_log[k]), 32'(k == 4));

    do_reset();
    cyc_a(2'b01, 1'b1, 1'b1);
    cyc_a(2'b01, 1'b1, 1'b1);
    cyc_a(2'b00, 1'b1, 1'b1);
    n0 = acc_log.size();
    repeat (6) cyc_a(2'b01, 1'b0, 1'b1);
    chk("bp_accepted", 32'(acc_log.size() - n0), 32'd2);
    repeat (6) cyc_a(2'b01, 1'b1, 1'b1);
    chk("bp_len", 32'(out_log.size() >= 4), 32'h1);
    for (int k = 0; k < 4 && k < out_log.size(); k++) chk("bp_order", 32'(out_log[k]), 32'(16'h100 + k));

    do_reset();
    repeat (1500) cyc_a({1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0)},
                        1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0));

    do_reset();
    for (int r = 0; r < 12; r++) begin
      b_send = tv[r].send; b_rdy = tv[r].rdy; b_oack = tv[r].oack;
      @(negedge CLK);
      chk($sformatf("b_ack[%0d]", r), 32'(b_ack), 32'(tv[r].ack));
      chk($sformatf("b_out_send[%0d]", r), 32'(b_osend), 32'(tv[r].os));
      if (tv[r].os) chk($sformatf("b_out_data[%0d]", r), 32'(b_odata), 32'(tv[r].od));
      chk($sformatf("b_grant[%0d]", r), 32'(b_gid), 32'(tv[r].gid));
      chk($sformatf("b_busy[%0d]", r), 32'(b_busy), 32'(tv[r].busy));
      @(posedge CLK);
      #1;
    end
    #2 RESET = 1'b1;
    #1;
    chk("rst_out_send", 32'(b_osend), 32'h0);
    chk("rst_out_data", 32'(b_odata), 32'h0);
    chk("rst_busy", 32'(b_busy), 32'h0);
    chk("rst_grant", 32'(b_gid), 32'h0);
    chk("rst_ack", 32'(b_ack), 32'h0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    b_send = 3'b111; b_rdy = 1'b1; b_oack = 1'b1;
    @(negedge CLK);
    chk("post_rst_idle", 32'(b_busy), 32'h0);
    chk("post_rst_out_send", 32'(b_osend), 32'h0);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("post_rst_busy", 32'(b_busy), 32'h1);
    chk("post_rst_grant", 32'(b_gid), 32'h0);
    chk("post_rst_ack", 32'(b_ack), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/actor_stream_rr_merge.md
Name: actor_stream_rr_merge

Overview:
- Round-robin scheduler that shares one downstream actor input port between N_IN upstream actor output ports, using the pipeline's SEND/ACK/RDY/COUNT token protocol.
- Grants are held for BURST_LEN tokens, typically one image row, so rows from different producers never interleave.
- Sits between parallel saliency feature actors and a single shared consumer actor.
- Includes a 2-entry output buffer, so full throughput is achieved with no combinational ACK path from output to input.

Parameters:
- N_IN, 2, number of producer ports (legal 2..4).
- DW, 16, token data width.
- BURST_LEN, 512, tokens per grant (legal 1..65535).
- BCW, 16, burst counter width; must satisfy 2^BCW >= BURST_LEN.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous active-high reset.
- In_DATA  in  N_IN*DW  producer tokens; slice i is port i.
- In_COUNT  in  N_IN*16  producer counts; ignored, every transfer is one token.
- In_SEND  in  N_IN  producer i presents a token.
- In_ACK  out  N_IN  token on port i consumed this cycle.
- Out_DATA  out  DW  token to consumer.
- Out_COUNT  out  16  constant 16'h1.
- Out_SEND  out  1  token valid to consumer.
- Out_ACK  in  1  consumer took the token.
- Out_RDY  in  1  consumer has space.
- Grant_ID  out  2  currently/last granted port.
- Busy  out  1  state==BURST.

Behaviour:
- Reset (async, active-high), all registers: state=IDLE, rr_ptr=0, Grant_ID=0, bcnt=0, fifo count=0, Out_SEND=0, In_ACK=0, Busy=0, Out_DATA=0.
- Transfer rules:
  - Input transfer on port i when In_SEND[i] & In_ACK[i].
  - Output transfer when Out_SEND & Out_ACK.
- FSM IDLE:
  - In_ACK all 0.
  - If any In_SEND is high, grant g = first i with In_SEND[i], searching from rr_ptr upward modulo N_IN.
  - Next cycle: state=BURST, Grant_ID=g, rr_ptr=(g+1) mod N_IN, bcnt=0.
  - If no request, stay IDLE with rr_ptr unchanged.
- FSM BURST:
  - In_ACK[Grant_ID] = In_SEND[Grant_ID] & (fcount<2), where fcount is registered.
  - All other In_ACK bits are 0.
  - Each input transfer increments bcnt.
  - The transfer with bcnt==BURST_LEN-1 returns state to IDLE next cycle and clears bcnt.
- Grant lock: if the granted producer deasserts SEND mid-burst, the grant is held indefinitely; other requesters wait. No timeout.
- Arbitration bubble: exactly one cycle in IDLE between bursts when a requester is waiting.
- FIFO:
  - 2 entries, registered.
  - Out_SEND = (fcount!=0) & Out_RDY; Out_DATA = head entry.
  - Push and pop in the same cycle leaves fcount unchanged, and data order is preserved.
  - fcount==2: In_ACK is low, so no push that cycle, even if a pop occurs.
- Latency: token accepted in cycle t appears on Out_DATA/Out_SEND at t+1 if the FIFO was empty and Out_RDY is high.
- Throughput: 1 token/cycle sustained while Out_RDY & Out_ACK stay high.
- Out_RDY low: Out_SEND is forced low and the FIFO holds. Input continues until fcount==2.
- BURST_LEN==1: per-token round robin with one bubble per token.
- Reset mid-burst: burst aborted, buffered tokens discarded, and the next arbitration starts at port 0.
- No token duplication or loss across grant changes. FIFO contents drain independently of the FSM.

Decomposition:
- Shared package `actor_stream_pkg`:
  - Token COUNT constant 16'h1.
  - FSM state typedef {IDLE, BURST}.
  - Helper function rr_pick(req, ptr, n).
  - clog2 helper.
- One sub-module: `actor_stream_fifo2` (2-entry registered FIFO: push/pop/fcount/head, async reset).
- FSM, burst counter and ACK steering remain in the top block.

Test Plan:
- Reset then idle: all In_SEND=0 for 10 cycles -> In_ACK=0, Out_SEND=0, Busy=0, Out_COUNT=16'h1.
- N_IN=2, BURST_LEN=4, both ports stream continuously (port0 values 0x100.., port1 values 0x200..), Out_RDY=Out_ACK=1 -> output order 0x100..0x103, 0x200..0x203, 0x104..; one input-side bubble per switch; Grant_ID alternates 0,1,0.
- Port0 granted, drops SEND after 2 of 4 tokens for 5 cycles while port1 requests -> In_ACK[1] stays 0; port0 finishes 2 more tokens, then port1 is granted.
- Backpressure: Out_RDY=0 for 6 cycles mid-burst -> exactly 2 tokens accepted then In_ACK low; after Out_RDY=1 order is intact, no loss or duplicates.
- BURST_LEN=1, N_IN=3, all requesting -> grants 0,1,2,0; one token each.
- RESET asserted asynchronously mid-burst with fcount=2 -> outputs zero immediately; after release, first grant goes to port 0 even if rr_ptr was 2.
